// File: rtl/sha2_msg_padder.sv
// SHA-256 message padder: passes message words through and appends
// the 0x80 marker, zero fill and 64-bit bit length in 16-word blocks.
module sha2_msg_padder #(
  parameter int LenCntWidth = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] in_data_i,
  input  logic [1:0]  in_bytes_i,
  input  logic        in_last_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] out_data_o,
  output logic        out_last_word_o,
  output logic        out_last_block_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    MSG, PAD_ONE, ZERO, LEN_HI, LEN_LO
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             idx;
  logic [LenCntWidth-1:0] bit_cnt;

  logic        load;
  logic        accept;
  logic        produce;
  logic        prod_lb;
  logic [31:0] prod_data;
  logic [31:0] tail;
  logic [2:0]  nbytes;
  logic [63:0] len64;

  assign load       = !out_valid_o || out_ready_i;
  assign in_ready_o = (state == MSG) && load;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state != MSG);
  assign len64      = 64'(bit_cnt);

  assign nbytes = (!in_last_i || in_bytes_i == 2'd0)
                ? 3'd4 : {1'b0, in_bytes_i};

  // Final partial word: keep valid lanes, marker in the next lane
  always_comb begin
    tail = in_data_i;
    unique case (in_bytes_i)
      2'd1:    tail = {in_data_i[31:24], 24'h80_0000};
      2'd2:    tail = {in_data_i[31:16], 16'h8000};
      2'd3:    tail = {in_data_i[31:8], 8'h80};
      default: tail = in_data_i;
    endcase
  end

  always_comb begin
    produce   = 1'b0;
    prod_lb   = 1'b0;
    prod_data = '0;
    state_nxt = state;
    unique case (state)
      MSG: begin
        if (accept) begin
          produce   = 1'b1;
          prod_data = in_last_i ? tail : in_data_i;
          if (in_last_i)
            state_nxt = (nbytes == 3'd4) ? PAD_ONE : ZERO;
        end
      end
      PAD_ONE: begin
        if (load) begin
          produce   = 1'b1;
          prod_data = 32'h8000_0000;
          state_nxt = ZERO;
        end
      end
      ZERO: begin
        // Index 14 is reserved for the length; no word this cycle
        if (idx == 4'd14) state_nxt = LEN_HI;
        else if (load)    produce   = 1'b1;
      end
      LEN_HI: begin
        if (load) begin
          produce   = 1'b1;
          prod_data = len64[63:32];
          state_nxt = LEN_LO;
        end
      end
      LEN_LO: begin
        if (load) begin
          produce   = 1'b1;
          prod_lb   = 1'b1;
          prod_data = len64[31:0];
          state_nxt = MSG;
        end
      end
      default: state_nxt = MSG;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= MSG;
      idx              <= '0;
      bit_cnt          <= '0;
      out_valid_o      <= 1'b0;
      out_data_o       <= '0;
      out_last_word_o  <= 1'b0;
      out_last_block_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        bit_cnt <= bit_cnt + LenCntWidth'({nbytes, 3'b000});
      else if (produce && state == LEN_LO)
        bit_cnt <= '0;
      if (produce)
        idx <= idx + 4'd1;
      if (load) begin
        out_valid_o      <= produce;
        out_data_o       <= prod_data;
        out_last_word_o  <= produce && (idx == 4'd15);
        out_last_block_o <= prod_lb;
      end
    end
  end

endmodule
